// File: rtl/reg_dump_ctrl.sv
// -----------------------------------------------------------------------------
// reg_dump_ctrl
//
// Lets a core run for a fixed number of un-halted clock edges, then stalls it
// and streams the register file out over a valid/ready port, one word per
// register, in index order 0..REG_NUM-1. After the last word is accepted the
// core stays halted and done_o is raised until the next reset.
//
// Parameters
//   END_CYCLE : un-halted core edges before the dump starts (1 .. 2^32-1)
//   REG_NUM   : number of register-file entries dumped (1 .. 32)
//   DATA_W    : register data width
//
// Ports
//   clk_i        in   single clock, rising edge
//   rst_i        in   asynchronous, active-low reset
//   halt_o       out  core stall (freezes PC and register-file writes)
//   rf_raddr_o   out  register-file read address
//   rf_rdata_i   in   register-file read data, combinational from rf_raddr_o
//   dump_valid_o out  dump word available
//   dump_ready_i in   sink accepts dump word
//   dump_idx_o   out  register index of the current dump word
//   dump_data_o  out  register value of the current dump word
//   done_o       out  all REG_NUM words accepted
//   cycle_cnt_o  out  number of un-halted core cycles seen
// -----------------------------------------------------------------------------
module reg_dump_ctrl #(
  parameter int unsigned END_CYCLE = 100,
  parameter int unsigned REG_NUM   = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              halt_o,
  output logic [4:0]        rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [4:0]        dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              done_o,
  output logic [31:0]       cycle_cnt_o
);

  // RUN : core executing, cycle counter running
  // RD  : register file addressed with the current index, data captured next edge
  // TX  : word presented on the dump port, waiting for the sink
  // DONE: every word delivered, core held until reset
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    RD   = 2'd1,
    TX   = 2'd2,
    DONE = 2'd3
  } state_t;

  // The transition out of RUN happens on the edge where the counter still
  // reads END_CYCLE-1, so the counter lands exactly on END_CYCLE and the core
  // has seen END_CYCLE un-halted edges.
  localparam logic [31:0] LAST_CYCLE = 32'(END_CYCLE - 1);
  localparam logic [4:0]  LAST_IDX   = 5'(REG_NUM - 1);

  state_t              state_reg;
  logic [31:0]         cycle_cnt_reg;
  logic [4:0]          idx_reg;
  logic                halt_reg;
  logic [4:0]          raddr_reg;
  logic                valid_reg;
  logic [4:0]          dump_idx_reg;
  logic [DATA_W-1:0]   dump_data_reg;
  logic                done_reg;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg     <= RUN;
      cycle_cnt_reg <= '0;
      idx_reg       <= '0;
      halt_reg      <= 1'b0;
      raddr_reg     <= '0;
      valid_reg     <= 1'b0;
      dump_idx_reg  <= '0;
      dump_data_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
          if (cycle_cnt_reg == LAST_CYCLE) begin
            // Halt is registered here so it is already high in the first
            // cycle of RD; the read address is presented at the same time.
            state_reg <= RD;
            halt_reg  <= 1'b1;
            raddr_reg <= idx_reg;
          end
        end

        RD: begin
          // Read data is combinational from the address presented during
          // this cycle, so capture it now; it stays frozen through TX even
          // if the register file output moves.
          dump_data_reg <= rf_rdata_i;
          dump_idx_reg  <= idx_reg;
          valid_reg     <= 1'b1;
          state_reg     <= TX;
        end

        TX: begin
          // Ready is only looked at here, so a sink that raises ready early
          // cannot cause a transfer before a word is actually on the port.
          if (dump_ready_i) begin
            valid_reg <= 1'b0;
            if (idx_reg == LAST_IDX) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
              raddr_reg <= '0;
            end else begin
              idx_reg   <= idx_reg + 5'd1;
              raddr_reg <= idx_reg + 5'd1;
              state_reg <= RD;
            end
          end
        end

        DONE: begin
          // Terminal: everything holds until the next reset.
          state_reg <= DONE;
        end

        default: begin
          state_reg <= RUN;
        end
      endcase
    end
  end

  assign halt_o       = halt_reg;
  assign rf_raddr_o   = raddr_reg;
  assign dump_valid_o = valid_reg;
  assign dump_idx_o   = dump_idx_reg;
  assign dump_data_o  = dump_data_reg;
  assign done_o       = done_reg;
  assign cycle_cnt_o  = cycle_cnt_reg;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_dump_ctrl
//
// Main instance: END_CYCLE=100, REG_NUM=32, register file reg[i] = i*3 (+ an
// optional offset used to disturb the read data mid-transfer).
// Second instance: END_CYCLE=1, REG_NUM=1, ready tied high.
//
// A timeline model (edges since reset, words accepted so far) predicts the
// main instance outputs and is compared every falling edge; directed phases
// add literal expectations for the key moments.
// -----------------------------------------------------------------------------
module tb_reg_dump_ctrl;

  localparam int END_C = 100;
  localparam int NREG  = 32;
  localparam int DW    = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  // main instance
  logic          halt;
  logic [4:0]    raddr;
  logic [DW-1:0] rdata;
  logic          valid;
  logic          ready = 1'b1;
  logic [4:0]    idx;
  logic [DW-1:0] data;
  logic          done;
  logic [31:0]   cnt;
  logic [31:0]   rf_offset = 32'd0;

  assign rdata = 32'(raddr) * 32'd3 + rf_offset;

  reg_dump_ctrl #(.END_CYCLE(END_C), .REG_NUM(NREG), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst_n), .halt_o(halt), .rf_raddr_o(raddr),
    .rf_rdata_i(rdata), .dump_valid_o(valid), .dump_ready_i(ready),
    .dump_idx_o(idx), .dump_data_o(data), .done_o(done), .cycle_cnt_o(cnt)
  );

  // minimal instance
  logic          halt2;
  logic [4:0]    raddr2;
  logic [DW-1:0] rdata2;
  logic          valid2;
  logic          ready2 = 1'b1;
  logic [4:0]    idx2;
  logic [DW-1:0] data2;
  logic          done2;
  logic [31:0]   cnt2;

  assign rdata2 = 32'(raddr2) * 32'd3 + 32'h100;

  reg_dump_ctrl #(.END_CYCLE(1), .REG_NUM(1), .DATA_W(DW)) dut2 (
    .clk_i(clk), .rst_i(rst_n), .halt_o(halt2), .rf_raddr_o(raddr2),
    .rf_rdata_i(rdata2), .dump_valid_o(valid2), .dump_ready_i(ready2),
    .dump_idx_o(idx2), .dump_data_o(data2), .done_o(done2), .cycle_cnt_o(cnt2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Timeline model: count edges until END_C, then alternate one read slot and
  // one presentation period per word until NREG words have been accepted.
  // ---------------------------------------------------------------------------
  int          m_cnt   = 0;
  bit          m_halt  = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_done  = 1'b0;
  int          m_nacc  = 0;
  logic [31:0] m_data  = 32'd0;

  function automatic logic [31:0] rf_val(input int i);
    return 32'(i) * 32'd3 + rf_offset;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   = 0;
      m_halt  = 1'b0;
      m_valid = 1'b0;
      m_done  = 1'b0;
      m_nacc  = 0;
      m_data  = 32'd0;
    end else if (!m_halt) begin
      m_cnt++;
      if (m_cnt == END_C) m_halt = 1'b1;
    end else if (!m_done) begin
      if (m_valid) begin
        if (ready) begin
          m_nacc++;
          m_valid = 1'b0;
          if (m_nacc == NREG) m_done = 1'b1;
        end
      end else begin
        m_valid = 1'b1;
        m_data  = rf_val(m_nacc);
      end
    end
  end

  // Accepted words as seen on the DUT port (pre-edge values at the edge).
  logic [4:0]  q_idx[$];
  logic [31:0] q_data[$];

  always @(posedge clk) begin
    if (rst_n && valid && ready) begin
      $display("TXN idx=%0d data=%0d t=%0t", idx, data, $time);
      q_idx.push_back(idx);
      q_data.push_back(data);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_halt", halt, 0);
      chk("rst_valid", valid, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_idx", idx, 0);
      chk("rst_data", data, 0);
      chk("rst_raddr", raddr, 0);
    end else begin
      chk("halt", halt, m_halt);
      chk("cycle_cnt", cnt, m_cnt);
      chk("valid", valid, m_valid);
      chk("done", done, m_done);
      if (m_valid) begin
        chk("dump_idx", idx, m_nacc);
        chk("dump_data", data, m_data);
      end
      if (!m_halt || m_done) chk("raddr_idle", raddr, 0);
      else if (!m_valid)     chk("raddr_rd", raddr, m_nacc);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1;
    q_idx.delete();
    q_data.delete();
    rf_offset = 32'd0;
    rst_n = 1'b1;
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_count"}, q_idx.size(), NREG);
    foreach (q_idx[i]) begin
      chk({tag, "_idx"}, q_idx[i], i);
      chk({tag, "_data"}, q_data[i], 3 * i);
    end
  endtask

  initial begin
    int  stall;
    int  t;
    bit  started;
    bit  hit;

    // ---------------- Phase A: nominal dump, ready tied high ----------------
    ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    chk("m2_init_cnt", cnt2, 0);
    chk("m2_init_halt", halt2, 0);
    for (int k = 1; k <= 170; k++) begin
      @(negedge clk);
      case (k)
        1: begin
          chk("m2_halt_e1", halt2, 1);
          chk("m2_cnt_e1", cnt2, 1);
          chk("m2_valid_e1", valid2, 0);
          chk("m2_raddr_e1", raddr2, 0);
        end
        2: begin
          chk("m2_valid_e2", valid2, 1);
          chk("m2_idx_e2", idx2, 0);
          chk("m2_data_e2", data2, 32'h100);
          chk("m2_done_e2", done2, 0);
        end
        3: begin
          chk("m2_done_e3", done2, 1);
          chk("m2_valid_e3", valid2, 0);
          chk("m2_halt_e3", halt2, 1);
        end
        99: begin
          chk("a_halt_e99", halt, 0);
          chk("a_cnt_e99", cnt, 99);
        end
        100: begin
          chk("a_halt_e100", halt, 1);
          chk("a_cnt_e100", cnt, 100);
          chk("a_valid_e100", valid, 0);
        end
        101: begin
          chk("a_valid_e101", valid, 1);
          chk("a_idx_e101", idx, 0);
          chk("a_data_e101", data, 0);
        end
        163: chk("a_done_e163", done, 0);
        164: begin
          chk("a_done_e164", done, 1);
          chk("a_valid_e164", valid, 0);
          chk("a_cnt_e164", cnt, 100);
        end
        170: chk("a_done_hold", done, 1);
        default: ;
      endcase
    end
    check_words("a_words");

    // ---------------- Phase B: backpressure on idx 7, data disturbed --------
    do_reset();
    stall = 0;
    hit = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done) begin
        hit = 1'b1;
        break;
      end
      if (valid && idx == 5'd7 && stall < 5) begin
        if (stall == 4) begin
          chk("b_stall_idx", idx, 7);
          chk("b_stall_data", data, 21);
          chk("b_stall_words", q_idx.size(), 7);
        end
        stall++;
        #1;
        ready = 1'b0;
        if (stall == 2) rf_offset = 32'h55;
      end else begin
        #1;
        ready = 1'b1;
        rf_offset = 32'd0;
      end
    end
    if (!hit) chk("b_timeout", 0, 1);
    chk("b_stall_cycles", stall, 5);
    check_words("b_words");

    // ---------------- Phase C: ready toggling, then reset in TX at idx 12 ---
    ready = 1'b0;
    do_reset();
    ready = 1'b0;
    started = 1'b0;
    hit = 1'b0;
    t = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (started) t++;
      if (!started && halt) begin
        chk("c_rd_valid", valid, 0);
        started = 1'b1;
        t = 0;
      end
      if (started && t == 1) begin
        chk("c_tx1_valid", valid, 1);
        chk("c_tx1_idx", idx, 0);
      end
      if (started && t == 2) begin
        chk("c_tx2_valid", valid, 1);
        chk("c_tx2_idx", idx, 0);
        chk("c_tx2_words", q_idx.size(), 0);
      end
      if (started && valid && idx == 5'd12) begin
        hit = 1'b1;
        break;
      end
      #1;
      if (started) ready = (t == 0) ? 1'b1 : ~ready;
    end
    if (!hit) chk("c_timeout", 0, 1);

    // Asynchronous reset in the middle of a cycle.
    #2 rst_n = 1'b0;
    #1;
    chk("d_async_halt", halt, 0);
    chk("d_async_valid", valid, 0);
    chk("d_async_idx", idx, 0);
    chk("d_async_data", data, 0);
    chk("d_async_cnt", cnt, 0);
    chk("d_async_done", done, 0);
    chk("d_async_raddr", raddr, 0);
    @(negedge clk);
    #1;
    q_idx.delete();
    q_data.delete();
    ready = 1'b1;
    rst_n = 1'b1;
    hit = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 99)  chk("d_valid_e99", valid, 0);
      if (k == 100) begin
        chk("d_halt_e100", halt, 1);
        chk("d_valid_e100", valid, 0);
      end
      if (k == 101) begin
        chk("d_valid_e101", valid, 1);
        chk("d_idx_e101", idx, 0);
        chk("d_data_e101", data, 0);
      end
      if (done) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) chk("d_timeout", 0, 1);
    check_words("d_words");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_dump_ctrl.md
REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

Interface
REQ-001 SHALL have parameter END_CYCLE, default 100, number of un-halted core clock edges before the dump starts (legal range 1 to 2^32-1).
REQ-002 SHALL have parameter REG_NUM, default 32, number of register-file entries dumped (legal range 1 to 32).
REQ-003 SHALL have parameter DATA_W, default 32, register data width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port halt_o  output  1  core stall; high freezes PC and register-file writes.
REQ-007 SHALL have port rf_raddr_o  output  5  register-file read address.
REQ-008 SHALL have port rf_rdata_i  input  DATA_W  register-file read data, combinational from rf_raddr_o.
REQ-009 SHALL have port dump_valid_o  output  1  dump word available.
REQ-010 SHALL have port dump_ready_i  input  1  sink accepts dump word.
REQ-011 SHALL have port dump_idx_o  output  5  register index of current dump word.
REQ-012 SHALL have port dump_data_o  output  DATA_W  register value of current dump word.
REQ-013 SHALL have port done_o  output  1  all REG_NUM words accepted.
REQ-014 SHALL have port cycle_cnt_o  output  32  count of un-halted core cycles.

Function
REQ-015 SHALL implement FSM states RUN, RD, TX, DONE; reset state RUN.
REQ-016 In RUN: cycle_cnt_o +1 per rising edge; halt_o=0.
REQ-017 RUN -> RD on the edge where cycle_cnt_o == END_CYCLE-1 (cycle_cnt_o becomes END_CYCLE); core thus sees exactly END_CYCLE un-halted edges.
REQ-018 halt_o SHALL be 1 in RD, TX, DONE, registered, asserting in the same cycle the state leaves RUN.
REQ-019 cycle_cnt_o SHALL hold its value outside RUN; no wrap possible for legal END_CYCLE.
REQ-020 In RD: rf_raddr_o = current index; on next edge capture rf_rdata_i into dump_data_o, index into dump_idx_o, set dump_valid_o=1, go TX.
REQ-021 In TX: dump_valid_o=1; dump_idx_o, dump_data_o stable until handshake (dump_valid_o & dump_ready_i at rising edge).
REQ-022 On TX handshake: index == REG_NUM-1 -> DONE, dump_valid_o=0; else index +1, dump_valid_o=0, go RD.
REQ-023 Minimum throughput: one word per 2 cycles (RD then TX with ready already high); dump_valid_o SHALL never be high in RD.
REQ-024 dump_ready_i SHALL be ignored outside TX; ready high before valid SHALL NOT cause a transfer.
REQ-025 Index order SHALL be 0,1,...,REG_NUM-1, each exactly once.
REQ-026 In DONE: done_o=1, halt_o=1, dump_valid_o=0; state held until reset.
REQ-027 rf_raddr_o SHALL be 0 in RUN and DONE.

Reset
REQ-028 rst_i low SHALL immediately (asynchronously) set state RUN, cycle_cnt_o=0, index=0, halt_o=0, dump_valid_o=0, dump_idx_o=0, dump_data_o=0, done_o=0, rf_raddr_o=0.
REQ-029 Reset asserted mid-dump (RD/TX) SHALL abort the transfer with no further valid word; after release, a full new run of END_CYCLE cycles precedes the next dump.
REQ-030 First count SHALL occur on the first rising edge after rst_i deasserts.

Verification
REQ-031 END_CYCLE=100, REG_NUM=32, ready tied 1, rf model reg[i]=i*3 -> halt_o rises after edge 100, cycle_cnt_o=100, 32 words idx 0..31 data 0..93, done_o after 64 cycles of dump.
REQ-032 Backpressure: ready low 5 cycles on word idx 7 (data 21) -> valid held, idx/data stable 5 cycles, then transfer; total words 32, no duplicates.
REQ-033 Ready high only during RD cycles (toggling each cycle out of phase) -> no transfer; stall until ready aligns with TX.
REQ-034 Reset pulse while in TX at idx 12 -> all outputs zero immediately; after release, dump restarts from idx 0 after another 100 cycles.
REQ-035 END_CYCLE=1, REG_NUM=1 -> halt_o after first edge, one word idx 0, done_o following handshake.
REQ-036 rf model changes value during TX -> dump_data_o keeps the value captured in RD.
